// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: major opcodes,
// FSM state encoding, instruction classes and datapath select encodings.
package multicycle_ctrl_pkg;

   // RV32I major opcodes handled by the multi-cycle sequencer
   localparam logic [6:0] OP_Rtype = 7'b0110011;
   localparam logic [6:0] OP_Itype = 7'b0010011;
   localparam logic [6:0] OP_Load  = 7'b0000011;
   localparam logic [6:0] OP_Stype = 7'b0100011;
   localparam logic [6:0] OP_Btype = 7'b1100011;

   // Encoding is visible on state_o, so values are fixed
   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ClsR,
      ClsI,
      ClsLoad,
      ClsStore,
      ClsBranch,
      ClsIllegal
   } inst_class_t;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;

   localparam logic WB_ALU = 1'b0;
   localparam logic WB_MEM = 1'b1;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decode for the multi-cycle controller.
// Ports:
//   opcode_i   - inst[6:0]
//   funct3_i   - inst[14:12]
//   funct7_5_i - inst[30]
//   cls_o      - instruction class (ClsIllegal for unsupported opcodes)
//   alu_sel_o  - ALU op {funct7[5],funct3}
//   bsel_o     - ALU B operand is the immediate
//   imm_sel_o  - immediate format
//   illegal_o  - opcode not supported
module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7_5_i,
   output inst_class_t cls_o,
   output logic [3:0]  alu_sel_o,
   output logic        bsel_o,
   output logic [2:0]  imm_sel_o,
   output logic        illegal_o
);

   always_comb begin
      cls_o     = ClsIllegal;
      alu_sel_o = ALU_ADD;
      bsel_o    = 1'b0;
      imm_sel_o = IMM_I;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_Rtype: begin
            cls_o     = ClsR;
            alu_sel_o = {funct7_5_i, funct3_i};
         end
         OP_Itype: begin
            cls_o  = ClsI;
            bsel_o = 1'b1;
            // funct7[5] is an immediate bit except for SRLI/SRAI
            alu_sel_o = (funct3_i == 3'b101) ? {funct7_5_i, funct3_i} : {1'b0, funct3_i};
         end
         OP_Load: begin
            cls_o  = ClsLoad;
            bsel_o = 1'b1;
         end
         OP_Stype: begin
            cls_o     = ClsStore;
            bsel_o    = 1'b1;
            imm_sel_o = IMM_S;
         end
         OP_Btype: begin
            cls_o     = ClsBranch;
            alu_sel_o = ALU_SUB;
            imm_sel_o = IMM_B;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Drives datapath strobes and owns the imem/dmem handshakes, each guarded by
// a ready watchdog (MEM_TIMEOUT cycles, 0 disables).
// Ports:
//   clk_i, rst_i (async, active-high)
//   inst_i, br_taken_i, imem_ready_i, dmem_ready_i           - inputs
//   imem_req_o, ir_we_o, dmem_req_o, dmem_we_o               - memory side
//   pc_we_o, pc_sel_o, reg_we_o, alu_sel_o, bsel_o,
//   imm_sel_o, wb_sel_o                                      - datapath
//   state_o, illegal_o, bus_err_o                            - status
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] inst_i,
   input  logic        br_taken_i,
   input  logic        imem_ready_i,
   input  logic        dmem_ready_i,
   output logic        imem_req_o,
   output logic        ir_we_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic        pc_we_o,
   output logic        pc_sel_o,
   output logic        reg_we_o,
   output logic [3:0]  alu_sel_o,
   output logic        bsel_o,
   output logic [2:0]  imm_sel_o,
   output logic        wb_sel_o,
   output logic [2:0]  state_o,
   output logic        illegal_o,
   output logic        bus_err_o
);

   localparam bit          WdogEn = (MEM_TIMEOUT > 0);
   localparam int unsigned CntW   = WdogEn ? $clog2(MEM_TIMEOUT + 1) : 1;
   // Last wait cycle: without ready here the count reaches MEM_TIMEOUT
   localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            illegal_q, illegal_d;
   logic            bus_err_q, bus_err_d;
   logic            mem_wait, timeout, wr_ok;

   inst_class_t cls;
   logic [3:0]  dec_alu_sel;
   logic        dec_bsel, dec_illegal;
   logic [2:0]  dec_imm_sel;

   logic unused_inst;
   assign unused_inst = ^{inst_i[31], inst_i[29:15], inst_i[11:7], dec_illegal};

   multicycle_ctrl_decode u_decode (
      .opcode_i   (inst_i[6:0]),
      .funct3_i   (inst_i[14:12]),
      .funct7_5_i (inst_i[30]),
      .cls_o      (cls),
      .alu_sel_o  (dec_alu_sel),
      .bsel_o     (dec_bsel),
      .imm_sel_o  (dec_imm_sel),
      .illegal_o  (dec_illegal)
   );

   assign timeout = WdogEn && (cnt_q == CntLast);

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      mem_wait  = 1'b0;
      case (state_q)
         StFetch: begin
            mem_wait = 1'b1;
            if (imem_ready_i) begin
               state_d = StDecode;
            end else if (timeout) begin
               state_d   = StTrap;
               bus_err_d = 1'b1;
            end
         end
         StDecode: begin
            if (cls == ClsIllegal) begin
               state_d   = StTrap;
               illegal_d = 1'b1;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            case (cls)
               ClsR, ClsI:        state_d = StWb;
               ClsLoad, ClsStore: state_d = StMem;
               ClsBranch:         state_d = StFetch;
               default:           state_d = StTrap;
            endcase
         end
         StMem: begin
            mem_wait = 1'b1;
            if (dmem_ready_i) begin
               state_d = (cls == ClsLoad) ? StWb : StFetch;
            end else if (timeout) begin
               state_d   = StTrap;
               bus_err_d = 1'b1;
            end
         end
         StWb:    state_d = StFetch;
         StTrap:  state_d = StTrap;
         default: state_d = StFetch;
      endcase

      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (WdogEn && mem_wait) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Write strobes are masked while reset is high so an abort never leaks a write
   assign wr_ok = ~rst_i;

   always_comb begin
      imem_req_o = 1'b0;
      ir_we_o    = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      pc_we_o    = 1'b0;
      pc_sel_o   = 1'b0;
      reg_we_o   = 1'b0;
      alu_sel_o  = 4'b0000;
      bsel_o     = 1'b0;
      imm_sel_o  = IMM_I;
      wb_sel_o   = WB_ALU;
      case (state_q)
         StFetch: begin
            imem_req_o = 1'b1;
            ir_we_o    = imem_ready_i & wr_ok;
         end
         StExec: begin
            alu_sel_o = dec_alu_sel;
            bsel_o    = dec_bsel;
            imm_sel_o = dec_imm_sel;
            if (cls == ClsBranch) begin
               pc_we_o  = wr_ok;
               pc_sel_o = br_taken_i;
            end
         end
         StMem: begin
            alu_sel_o  = dec_alu_sel;
            bsel_o     = dec_bsel;
            imm_sel_o  = dec_imm_sel;
            dmem_req_o = wr_ok;
            dmem_we_o  = (cls == ClsStore) & wr_ok;
            pc_we_o    = (cls == ClsStore) & dmem_ready_i & wr_ok;
         end
         StWb: begin
            reg_we_o = wr_ok;
            wb_sel_o = (cls == ClsLoad) ? WB_MEM : WB_ALU;
            pc_we_o  = wr_ok;
         end
         default: ;
      endcase
   end

   assign state_o   = state_q;
   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4).
module tb_multicycle_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        br, irdy, drdy;
   logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we;
   logic [3:0]  alu_sel;
   logic        bsel, wb_sel, illegal, bus_err;
   logic [2:0]  imm_sel, state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .inst_i       (inst),
      .br_taken_i   (br),
      .imem_ready_i (irdy),
      .dmem_ready_i (drdy),
      .imem_req_o   (imem_req),
      .ir_we_o      (ir_we),
      .dmem_req_o   (dmem_req),
      .dmem_we_o    (dmem_we),
      .pc_we_o      (pc_we),
      .pc_sel_o     (pc_sel),
      .reg_we_o     (reg_we),
      .alu_sel_o    (alu_sel),
      .bsel_o       (bsel),
      .imm_sel_o    (imm_sel),
      .wb_sel_o     (wb_sel),
      .state_o      (state),
      .illegal_o    (illegal),
      .bus_err_o    (bus_err)
   );

   typedef struct packed {
      logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we;
      logic [3:0] alu_sel;
      logic       bsel;
      logic [2:0] imm_sel;
      logic       wb_sel;
      logic [2:0] state;
      logic       illegal, bus_err;
   } outs_t;

   outs_t act;
   always_comb act = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we,
                      alu_sel, bsel, imm_sel, wb_sel, state, illegal, bus_err};

   int n_cmp = 0;
   int n_bad = 0;
   logic m_ill = 1'b0;
   logic m_be  = 1'b0;

   task automatic chk(input string name, input outs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h (state %0d) want %h (state %0d)", name, act, act.state,
                  exp, exp.state);
      end
   endtask

   task automatic chk_val(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 illegal
   function automatic int cls_of(input logic [31:0] ins);
      case (ins[6:0])
         7'b0110011: return 0;
         7'b0010011: return 1;
         7'b0000011: return 2;
         7'b0100011: return 3;
         7'b1100011: return 4;
         default:    return 5;
      endcase
   endfunction

   // Expected outputs for a cycle in phase ph (0 fetch .. 5 trap)
   function automatic outs_t model(input int ph, input logic [31:0] ins, input logic ir,
                                   input logic dr, input logic b);
      outs_t      o;
      int         c;
      logic [2:0] f3;
      c  = cls_of(ins);
      f3 = ins[14:12];
      o  = '0;
      o.state   = 3'(ph);
      o.illegal = m_ill;
      o.bus_err = m_be;
      case (ph)
         0: begin
            o.imem_req = 1'b1;
            o.ir_we    = ir;
         end
         2, 3: begin
            case (c)
               0: o.alu_sel = {ins[30], f3};
               1: begin
                  o.bsel    = 1'b1;
                  o.alu_sel = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
               end
               2: o.bsel = 1'b1;
               3: begin
                  o.bsel    = 1'b1;
                  o.imm_sel = 3'd1;
               end
               4: if (ph == 2) begin
                  o.alu_sel = 4'b1000;
                  o.imm_sel = 3'd2;
                  o.pc_we   = 1'b1;
                  o.pc_sel  = b;
               end
               default: ;
            endcase
            if (ph == 3) begin
               o.dmem_req = 1'b1;
               o.dmem_we  = (c == 3);
               o.pc_we    = (c == 3) && dr;
            end
         end
         4: begin
            o.reg_we = 1'b1;
            o.wb_sel = (c == 2);
            o.pc_we  = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

   task automatic do_reset;
      outs_t exp;
      rst  = 1'b1;
      irdy = 1'b1;
      drdy = 1'b1;
      #1;
      exp = '0;
      exp.imem_req = 1'b1;
      chk("reset", exp);
      tick();
      tick();
      rst   = 1'b0;
      irdy  = 1'b0;
      drdy  = 1'b0;
      m_ill = 1'b0;
      m_be  = 1'b0;
   endtask

   // Runs one instruction from FETCH entry. iw/dw are ready delays (>= TO means never).
   task automatic run_instr(input string name, input logic [31:0] ins, input int iw,
                            input int dw, input logic b, input int hold_trap,
                            output int cycles, output bit trapped, output logic [3:0] ex_alu);
      int c;
      bit to_wb;
      c       = cls_of(ins);
      cycles  = 0;
      trapped = 1'b0;
      to_wb   = 1'b0;
      ex_alu  = 4'hx;
      inst    = ins;
      br      = b;
      for (int k = 0; ; k++) begin
         irdy = (k == iw);
         drdy = 1'($urandom);
         #1;
         chk({name, "/fetch"}, model(0, ins, irdy, drdy, b));
         cycles++;
         tick();
         if (irdy) break;
         if (k == TO - 1) begin
            m_be    = 1'b1;
            trapped = 1'b1;
            break;
         end
      end
      if (!trapped) begin
         irdy = 1'($urandom);
         drdy = 1'($urandom);
         #1;
         chk({name, "/decode"}, model(1, ins, irdy, drdy, b));
         cycles++;
         tick();
         if (c == 5) begin
            m_ill   = 1'b1;
            trapped = 1'b1;
         end
      end
      if (!trapped) begin
         irdy = 1'($urandom);
         drdy = 1'($urandom);
         #1;
         chk({name, "/exec"}, model(2, ins, irdy, drdy, b));
         ex_alu = alu_sel;
         cycles++;
         tick();
         to_wb = (c == 0 || c == 1);
         if (c == 2 || c == 3) begin
            for (int k = 0; ; k++) begin
               drdy = (k == dw);
               irdy = 1'($urandom);
               #1;
               chk({name, "/mem"}, model(3, ins, irdy, drdy, b));
               cycles++;
               tick();
               if (drdy) begin
                  to_wb = (c == 2);
                  break;
               end
               if (k == TO - 1) begin
                  m_be    = 1'b1;
                  trapped = 1'b1;
                  break;
               end
            end
         end
      end
      if (to_wb) begin
         irdy = 1'($urandom);
         drdy = 1'($urandom);
         #1;
         chk({name, "/wb"}, model(4, ins, irdy, drdy, b));
         cycles++;
         tick();
      end
      if (trapped) begin
         for (int k = 0; k < hold_trap; k++) begin
            irdy = 1'($urandom);
            drdy = 1'($urandom);
            br   = 1'($urandom);
            #1;
            chk({name, "/trap"}, model(5, ins, irdy, drdy, br));
            tick();
         end
      end
      irdy = 1'b0;
      drdy = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [31:0] ins;
      int          iw, dw;
      logic        b;
      int          exp_cyc;
      logic [3:0]  exp_alu;
   } vec_t;

   vec_t vecs[9];
   logic [6:0] ops[5];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int          cyc;
      bit          tr;
      logic [3:0]  ea;
      logic [31:0] ri;
      outs_t       exp;

      vecs[0] = '{"add",       32'h002081B3, 0, 0, 1'b0, 4, 4'b0000};
      vecs[1] = '{"srai",      32'h40315093, 3, 0, 1'b0, 7, 4'b1101};
      vecs[2] = '{"lw",        32'h0080A283, 0, 2, 1'b0, 7, 4'b0000};
      vecs[3] = '{"sw",        32'h0050A623, 0, 2, 1'b0, 6, 4'b0000};
      vecs[4] = '{"beq_t",     32'h00208463, 0, 0, 1'b1, 3, 4'b1000};
      vecs[5] = '{"beq_nt",    32'h00208463, 0, 0, 1'b0, 3, 4'b1000};
      vecs[6] = '{"sub",       32'h402081B3, 0, 0, 1'b0, 4, 4'b1000};
      vecs[7] = '{"addi",      32'h00500093, 1, 0, 1'b0, 5, 4'b0000};
      vecs[8] = '{"xori_b30",  32'h40004093, 0, 0, 1'b0, 4, 4'b0100};
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

      rst  = 1'b1;
      inst = '0;
      br   = 1'b0;
      irdy = 1'b0;
      drdy = 1'b0;
      tick();
      do_reset();

      foreach (vecs[i]) begin
         run_instr(vecs[i].name, vecs[i].ins, vecs[i].iw, vecs[i].dw, vecs[i].b, 0, cyc, tr, ea);
         chk_val({vecs[i].name, "/latency"}, cyc, vecs[i].exp_cyc);
         chk_val({vecs[i].name, "/exec_alu"}, int'(ea), int'(vecs[i].exp_alu));
      end

      // Illegal opcode: trap holds with all strobes low, reset recovers
      run_instr("illegal", 32'h0000007F, 0, 0, 1'b0, 20, cyc, tr, ea);
      chk_val("illegal/trapped", int'(tr), 1);
      chk_val("illegal/flag", int'(illegal), 1);
      do_reset();
      run_instr("post_ill_add", 32'h002081B3, 0, 0, 1'b0, 0, cyc, tr, ea);
      chk_val("post_ill_add/latency", cyc, 4);

      // dmem never ready: bus error after TO MEM cycles
      run_instr("dmem_to", 32'h0080A283, 0, 99, 1'b0, 5, cyc, tr, ea);
      chk_val("dmem_to/cycles", cyc, 3 + TO);
      chk_val("dmem_to/bus_err", int'(bus_err), 1);
      do_reset();

      // Ready on the last allowed cycle wins
      run_instr("dmem_last", 32'h0080A283, 0, TO - 1, 1'b0, 0, cyc, tr, ea);
      chk_val("dmem_last/latency", cyc, 5 + TO - 1);
      chk_val("dmem_last/no_trap", int'(tr), 0);

      // imem never ready
      run_instr("imem_to", 32'h002081B3, 99, 0, 1'b0, 3, cyc, tr, ea);
      chk_val("imem_to/cycles", cyc, TO);
      do_reset();

      // Reset in the middle of MEM drops dmem_req at once
      inst = 32'h0050A623;
      irdy = 1'b1;
      #1;
      chk("rmid/fetch", model(0, inst, 1'b1, 1'b0, 1'b0));
      tick();
      irdy = 1'b0;
      #1;
      chk("rmid/decode", model(1, inst, 1'b0, 1'b0, 1'b0));
      tick();
      #1;
      chk("rmid/exec", model(2, inst, 1'b0, 1'b0, 1'b0));
      tick();
      #1;
      chk("rmid/mem", model(3, inst, 1'b0, 1'b0, 1'b0));
      tick();
      rst = 1'b1;
      #1;
      exp = '0;
      exp.imem_req = 1'b1;
      chk("rmid/abort", exp);
      tick();
      rst = 1'b0;
      run_instr("rmid/restart", 32'h002081B3, 0, 0, 1'b0, 0, cyc, tr, ea);

      // Random legal instructions with random memory delays
      for (int n = 0; n < 200; n++) begin
         ri      = $urandom;
         ri[6:0] = ops[$urandom_range(0, 4)];
         run_instr("rand", ri, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                   1'($urandom), 0, cyc, tr, ea);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core datapath: steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the datapath strobes: PC/IR write, register-file write, ALU select, B-mux, immediate and writeback select.
- Owns the instruction-memory and data-memory request/ready handshakes, with a timeout watchdog on each.
- Sits between the IR/PC/regfile/ALU datapath and the memory ports. Replaces single-cycle control for multi-cycle builds.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles for imem/dmem ready before bus-error trap; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset (see Behaviour)
- inst_i  in  32  instruction from IR; stable after ir_we_o
- br_taken_i  in  1  branch comparator result, valid in EXEC
- imem_ready_i  in  1  instruction memory data valid
- dmem_ready_i  in  1  data memory access complete
- imem_req_o  out  1  instruction fetch request
- ir_we_o  out  1  load IR
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  data memory write (stores)
- pc_we_o  out  1  PC update strobe
- pc_sel_o  out  1  0 = PC+4, 1 = branch target
- reg_we_o  out  1  regfile write enable
- alu_sel_o  out  4  ALU op {funct7[5],funct3} encoding
- bsel_o  out  1  ALU B operand: 1 = immediate
- imm_sel_o  out  3  0 = I, 1 = S, 2 = B
- wb_sel_o  out  1  0 = ALU, 1 = dmem read data
- state_o  out  3  current state, for debug
- illegal_o  out  1  sticky: illegal opcode trap
- bus_err_o  out  1  sticky: memory timeout trap

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- While rst_i is high: state = FETCH, wait counter = 0, illegal_o = 0, bus_err_o = 0.
- Outputs are decoded combinationally from state and inst_i (Moore on state).
- Every strobe is 0 outside the states listed below.
- The first cycle after reset release shows imem_req_o = 1.
- Reset mid-operation aborts immediately. No partial writes are issued after reset asserts.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - imem_req_o = 1.
  - On imem_req_o && imem_ready_i (may be the same cycle the request rises): ir_we_o = 1, go to DECODE.
- DECODE:
  - One cycle.
  - Opcode not in {0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch}: go to TRAP, set illegal_o.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: alu_sel_o = {funct7[5],funct3}, bsel_o = 0. Go to WB.
  - I-ALU: bsel_o = 1, imm_sel_o = I. alu_sel_o = {funct7[5],funct3} when funct3 = 101 (SRLI/SRAI), otherwise {0,funct3}. Go to WB.
  - Load/store: alu_sel_o = 0000 (ADD), bsel_o = 1, imm_sel_o = I (load) or S (store). Go to MEM.
  - Branch: alu_sel_o = 1000 (SUB), bsel_o = 0, imm_sel_o = B, pc_we_o = 1, pc_sel_o = br_taken_i. Go to FETCH.
- MEM:
  - dmem_req_o = 1 held until dmem_ready_i. dmem_we_o = 1 for store. ALU controls are held from EXEC.
  - On ready, load: go to WB.
  - On ready, store: pc_we_o = 1, pc_sel_o = 0, go to FETCH.
- WB:
  - reg_we_o = 1, wb_sel_o = 1 for load, pc_we_o = 1, pc_sel_o = 0. Go to FETCH.
- TRAP:
  - All strobes 0. Held until reset.
- Watchdog:
  - Counter width = $clog2(MEM_TIMEOUT+1). Increments each FETCH/MEM cycle without ready; clears on every state change.
  - Counter reaching MEM_TIMEOUT with ready low: go to TRAP, set bus_err_o.
  - Ready arriving in the same cycle as the limit: ready wins.
  - Ready while the corresponding req is low is ignored.
- Minimum latency, measured from FETCH entry with zero-wait memory:
  - Branch: 3 cycles.
  - R/I-ALU: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Decomposition:
- Opcode constants (OP_Rtype, OP_Itype, OP_Load, OP_Stype, OP_Btype), the state enum, and the imm_sel/wb_sel encodings go in a shared package, extending define.sv.
- One sub-module, ctrl_decode: combinational opcode → {class, alu_sel, bsel, imm_sel, illegal}.
- FSM and watchdog stay in multicycle_ctrl.

Test Plan:
- add x3,x1,x2 (0x002081B3), zero-wait imem → exactly 4 cycles; reg_we_o high only in WB; alu_sel_o = 0000 in EXEC.
- srai (funct7 = 0100000, funct3 = 101), imem ready after 3 cycles → alu_sel_o = 1101, bsel_o = 1; ir_we_o pulses once.
- lw then sw, dmem ready after 2 wait cycles → dmem_req_o held 3 cycles each.
  - lw: wb_sel_o = 1 in WB.
  - sw: dmem_we_o = 1, no reg_we_o, pc_we_o in final MEM cycle.
- beq, br_taken_i = 1 → pc_we_o = 1 and pc_sel_o = 1 in EXEC, then FETCH. Repeat with br_taken_i = 0 → pc_sel_o = 0.
- Opcode 0x7F → TRAP after DECODE, illegal_o = 1, all strobes stay 0 for 20 cycles.
  - rst_i pulse clears illegal_o and restarts FETCH.
- MEM_TIMEOUT = 4, dmem_ready_i never asserts → bus_err_o after 4 MEM cycles.
  - Ready on the 4th cycle → normal completion.
  - rst_i asserted mid-MEM → dmem_req_o drops in the same cycle.
